// File: rtl/islemci_paket.sv
// Constants and the fetch-state type used by the islemci core and its fetch unit.
package islemci_paket;

  localparam logic [31:0] NOP_BUYRUK = 32'h0000_0013;
  localparam int unsigned PS_ADIM    = 4;

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    GETIR = 2'd1,
    DUR   = 2'd2
  } getirme_durumu_e;

endpackage

// File: rtl/buyruk_kuyrugu.sv
// Synchronous prefetch FIFO carrying instruction word and its byte PC.
module buyruk_kuyrugu #(
  parameter int unsigned VERI_GEN = 32,
  parameter int unsigned DERINLIK = 4
) (
  input  logic                        saat,
  input  logic                        reset,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic                        flush_i,
  input  logic [VERI_GEN-1:0]         veri_i,
  input  logic [VERI_GEN-1:0]         ps_i,
  output logic [$clog2(DERINLIK):0]   sayi_o,
  output logic [VERI_GEN-1:0]         bas_veri_o,
  output logic [VERI_GEN-1:0]         bas_ps_o
);

  localparam int unsigned IS_W = $clog2(DERINLIK);

  logic [VERI_GEN-1:0] veri_q [DERINLIK];
  logic [VERI_GEN-1:0] ps_q   [DERINLIK];
  logic [IS_W-1:0]     oku_is_q, yaz_is_q;
  logic [IS_W:0]       sayi_q;
  logic                cek, it;

  assign cek = pop_i && (sayi_q != '0);
  assign it  = push_i && ((sayi_q != (IS_W+1)'(DERINLIK)) || cek);

  always_ff @(posedge saat) begin
    if (it && !flush_i) begin
      veri_q[yaz_is_q] <= veri_i;
      ps_q[yaz_is_q]   <= ps_i;
    end
  end

  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      oku_is_q <= '0;
      yaz_is_q <= '0;
      sayi_q   <= '0;
    end else if (flush_i) begin
      oku_is_q <= '0;
      yaz_is_q <= '0;
      sayi_q   <= '0;
    end else begin
      if (it)  yaz_is_q <= yaz_is_q + IS_W'(1);
      if (cek) oku_is_q <= oku_is_q + IS_W'(1);
      case ({it, cek})
        2'b10:   sayi_q <= sayi_q + (IS_W+1)'(1);
        2'b01:   sayi_q <= sayi_q - (IS_W+1)'(1);
        default: sayi_q <= sayi_q;
      endcase
    end
  end

  assign sayi_o     = sayi_q;
  assign bas_veri_o = veri_q[oku_is_q];
  assign bas_ps_o   = ps_q[oku_is_q];

endmodule

// File: rtl/buyruk_getirme_birimi.sv
// Instruction fetch unit: loadable program memory, sequential prefetch into a
// small queue, valid/ready delivery, flush-and-refetch on PC redirect.
module buyruk_getirme_birimi
  import islemci_paket::*;
#(
  parameter int unsigned VERI_GEN        = 32,
  parameter int unsigned BELLEK_DERINLIK = 64,
  parameter int unsigned KUYRUK_DERINLIK = 4
) (
  input  logic                               saat,
  input  logic                               reset,
  input  logic                               yukle_gecerli,
  input  logic [$clog2(BELLEK_DERINLIK)-1:0] yukle_adres,
  input  logic [VERI_GEN-1:0]                yukle_veri,
  input  logic                               baslat,
  input  logic                               hedef_gecerli,
  input  logic [VERI_GEN-1:0]                hedef_ps,
  output logic [VERI_GEN-1:0]                buyruk,
  output logic [VERI_GEN-1:0]                buyruk_ps,
  output logic                               buyruk_gecerli,
  input  logic                               buyruk_hazir,
  output logic                               bitti,
  output logic                               hata
);

  localparam int unsigned ADRES_W = $clog2(BELLEK_DERINLIK);
  localparam int unsigned SAYI_W  = $clog2(KUYRUK_DERINLIK) + 1;
  localparam logic [VERI_GEN-1:0] SON_PS = VERI_GEN'(BELLEK_DERINLIK * PS_ADIM);

  logic [VERI_GEN-1:0] bellek [BELLEK_DERINLIK];

  getirme_durumu_e     durum_q, durum_d;
  logic [VERI_GEN-1:0] fps_q, fps_d, fps_art;
  logic [VERI_GEN-1:0] oku_veri_q, oku_ps_q;
  logic                ucus_q, bitti_q, bitti_d, hata_q, hata_d;
  logic                oku, yonlendir, bosalt, cek;
  logic [SAYI_W-1:0]   kuyruk_sayi, dolu;
  logic [VERI_GEN-1:0] bas_veri, bas_ps;

  assign yonlendir = hedef_gecerli && (durum_q != BOS);
  assign bosalt    = baslat || yonlendir;
  // Reads still in flight reserve a slot, so a returning word always fits.
  assign dolu      = kuyruk_sayi + SAYI_W'(ucus_q);
  assign oku       = (durum_q == GETIR) && !bosalt && (fps_q < SON_PS) &&
                     (dolu < SAYI_W'(KUYRUK_DERINLIK));
  assign fps_art   = fps_q + VERI_GEN'(PS_ADIM);

  always_ff @(posedge saat) begin
    if (yukle_gecerli) bellek[yukle_adres] <= yukle_veri;
    if (oku)           oku_veri_q <= bellek[fps_q[ADRES_W+1:2]];
  end

  always_comb begin
    durum_d = durum_q;
    fps_d   = fps_q;
    bitti_d = bitti_q;
    hata_d  = hata_q;
    if (baslat) begin
      durum_d = GETIR;
      fps_d   = '0;
      bitti_d = 1'b0;
      hata_d  = 1'b0;
    end else if (yonlendir) begin
      if (hedef_ps[1:0] != 2'b00) begin
        hata_d  = 1'b1;
        durum_d = DUR;
      end else begin
        fps_d   = hedef_ps;
        bitti_d = (hedef_ps >= SON_PS);
        durum_d = (hedef_ps >= SON_PS) ? DUR : GETIR;
      end
    end else if (oku) begin
      fps_d = fps_art;
      if (fps_art >= SON_PS) begin
        bitti_d = 1'b1;
        durum_d = DUR;
      end
    end
  end

  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      durum_q  <= BOS;
      fps_q    <= '0;
      oku_ps_q <= '0;
      ucus_q   <= 1'b0;
      bitti_q  <= 1'b0;
      hata_q   <= 1'b0;
    end else begin
      durum_q  <= durum_d;
      fps_q    <= fps_d;
      ucus_q   <= oku;
      bitti_q  <= bitti_d;
      hata_q   <= hata_d;
      if (oku) oku_ps_q <= fps_q;
    end
  end

  buyruk_kuyrugu #(
    .VERI_GEN (VERI_GEN),
    .DERINLIK (KUYRUK_DERINLIK)
  ) u_kuyruk (
    .saat       (saat),
    .reset      (reset),
    .push_i     (ucus_q),
    .pop_i      (cek),
    .flush_i    (bosalt),
    .veri_i     (oku_veri_q),
    .ps_i       (oku_ps_q),
    .sayi_o     (kuyruk_sayi),
    .bas_veri_o (bas_veri),
    .bas_ps_o   (bas_ps)
  );

  assign buyruk_gecerli = (kuyruk_sayi != '0);
  assign cek            = buyruk_gecerli && buyruk_hazir;
  assign buyruk         = buyruk_gecerli ? bas_veri : VERI_GEN'(NOP_BUYRUK);
  assign buyruk_ps      = buyruk_gecerli ? bas_ps : '0;
  assign bitti          = bitti_q;
  assign hata           = hata_q;

endmodule

// File: doc/buyruk_getirme_birimi.md
# buyruk_getirme_birimi

Parametrised instruction-fetch unit that replaces hand-driven `buyruk` stimulus for the `islemci` core. It holds a loadable program memory and prefetches sequential instructions into a small queue. It presents instructions to the core through a valid/ready handshake and flushes and refetches when the core redirects the PC (taken branch, `jal`, `jalr`).

## Interface
- `VERI_GEN`, 32, instruction and PC width.
- `BELLEK_DERINLIK`, 64, program memory depth in words; power of two, ≥4.
- `KUYRUK_DERINLIK`, 4, prefetch queue depth; power of two, ≥2.
- `saat`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `yukle_gecerli`  in  1  program-load write strobe.
- `yukle_adres`  in  log2(BELLEK_DERINLIK)  word address for the load.
- `yukle_veri`  in  VERI_GEN  instruction word to store.
- `baslat`  in  1  one-cycle pulse: start fetching at PC 0 and clear `hata`/`bitti`.
- `hedef_gecerli`  in  1  redirect request from the core.
- `hedef_ps`  in  VERI_GEN  redirect target byte address.
- `buyruk`  out  VERI_GEN  instruction at the queue head.
- `buyruk_ps`  out  VERI_GEN  byte PC of `buyruk`.
- `buyruk_gecerli`  out  1  `buyruk`/`buyruk_ps` are valid.
- `buyruk_hazir`  in  1  the core accepts the head this cycle.
- `bitti`  out  1  fetch PC has run past the end of memory.
- `hata`  out  1  sticky misaligned-redirect error.

## Operation
- States: BOS (idle), GETIR (fetching), DUR (halted: `bitti` or `hata`).
- Reset drives the state to BOS, empties the queue and sets fetch PC `fps` to 0. Memory contents are not reset.
- Reset output values:
  - `buyruk` = 32'h0000_0013 (NOP).
  - `buyruk_ps` = 0.
  - `buyruk_gecerli`, `bitti`, `hata` = 0.
- `baslat` from any state: flush the queue, discard any in-flight read, set `fps`=0, clear `hata`/`bitti`, enter GETIR.
- GETIR issues one synchronous memory read per cycle at word `fps>>2`, then `fps += 4`.
  - A read issues only when (queue occupancy + in-flight reads) < `KUYRUK_DERINLIK`, so no read result is ever dropped.
- A handshake transfer occurs when `buyruk_gecerli && buyruk_hazir`; the head pops.
- When `fps>>2` reaches `BELLEK_DERINLIK`: stop issuing reads, set `bitti`, enter DUR. The queue keeps draining.
- Redirect with `hedef_ps[1:0]==0` in GETIR or DUR:
  - Flush the queue and the in-flight read, set `fps=hedef_ps`, clear `bitti`, re-enter GETIR.
  - Out-of-range targets go straight to DUR with `bitti`=1.
- Redirect with `hedef_ps[1:0]!=0`: flush, set `hata`=1, enter DUR. `hata` holds until `baslat` or reset.
- Redirect in BOS is ignored.
- Priority: `reset` > `baslat` > `hedef_gecerli` > normal fetch/pop.
- A transfer in the same cycle as a redirect still completes (the core took it). The flush then removes the remaining entries.
- Load port works in any state. A read and a write to the same word in the same cycle return the old data.
- When `buyruk_gecerli`=0, `buyruk` shows NOP.

## Timing
- Memory read latency is 1 cycle; the queue write is registered.
- `baslat` or an aligned redirect sampled at edge k gives the first `buyruk_gecerli`=1 after edge k+2.
- Steady state with `buyruk_hazir` held high: 1 instruction per cycle, no bubbles.
- Holding `buyruk_hazir` low: the queue fills to `KUYRUK_DERINLIK` and then fetch stalls with `fps` frozen. The head and `buyruk_ps` stay stable until accepted.
- `bitti` and `hata` are asserted after the edge that samples the causing condition.
- Asserting `reset` mid-operation clears state immediately, asynchronously to `saat`.

## Structure
- Shared package `islemci_paket`:
  - `NOP_BUYRUK` = 32'h0000_0013.
  - `PS_ADIM` = 4.
  - The fetch-state enum (BOS/GETIR/DUR).
- Sub-module `buyruk_kuyrugu`: parametrised synchronous FIFO.
  - Inputs: push, pop, flush.
  - Outputs: count, head data, head PC.
  - Flush takes priority over push.
- The top level holds the memory array, `fps`, the in-flight flag and the FSM.

## Test plan
- Load 32'h00730113 at address 0 and 32'h00510813 at address 1, pulse `baslat`, hold `hazir`=1:
  - 2 cycles later: `buyruk`=32'h00730113, `buyruk_ps`=0.
  - Next cycle: `buyruk`=32'h00510813, `buyruk_ps`=4.
- Fill all 64 words with their own indices, `hazir`=0 for 10 cycles:
  - The queue holds exactly 4 entries (PC 0,4,8,12) with the head stable.
  - Release `hazir`: PCs appear consecutively with no gap and no skip.
- Redirect `hedef_ps`=32'h40 while PC 8 is at the head, `hazir`=1:
  - Old entries vanish.
  - 2 cycles later `buyruk_ps`=32'h40 with memory word 16.
- Redirect `hedef_ps`=32'h42:
  - `hata`=1, `buyruk_gecerli`=0 next cycle, no further fetch.
  - `baslat` clears `hata` and refetches from PC 0.
- Run to the end with depth 64: after PC 252 is fetched, `bitti`=1. All 64 instructions are still delivered; none with PC 256.
- Assert `reset` low mid-stream with `hazir`=1:
  - Outputs immediately show NOP, PC 0 and `gecerli`=0.
  - Memory still holds the program: `baslat` after release replays 32'h00730113 first.
